// File: rtl/pc_seq_pkg.sv
//==============================================================================
// Module : pc_seq_pkg
// Brief  : Shared types, constants and PC helper for the pc_sequencer slice.
//          Build option: PC_SEQ_STACK_CIRCULAR_EN selects a circular return stack.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [1:0] {
    STK_NONE = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2
  } stack_op_t;

  localparam int   PC_RESET_VAL = 0;
  localparam logic PHASE_FETCH  = 1'b0;

`ifdef PC_SEQ_STACK_CIRCULAR_EN
  localparam bit STACK_CIRCULAR = 1'b1;
`else
  localparam bit STACK_CIRCULAR = 1'b0;
`endif

  // Callers truncate to their own address width, which gives the modulo wrap.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
//==============================================================================
// Module : ret_stack
// Brief  : DEPTH x WIDTH return-address LIFO with occupancy and full/empty.
//          CIRCULAR (from PC_SEQ_STACK_CIRCULAR_EN) lets a full push overwrite the oldest entry.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 12,
  parameter bit CIRCULAR = 1'b0,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int SP_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  stack_op_t        op,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [SP_W-1:0]  r_sp;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_sp == SP_W'(DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_push  = (op == STK_PUSH) && (!w_full || CIRCULAR);
  assign w_pop   = (op == STK_POP) && !w_empty;

  // r_ptr is the next free slot; once full it also addresses the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      r_sp  <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!w_full) r_sp <= r_sp + SP_W'(1);
    end else if (w_pop) begin
      r_ptr <= r_ptr - PTR_W'(1);
      r_sp  <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_ptr] <= push_data;
  end

  assign top   = r_mem[r_ptr - PTR_W'(1)];
  assign sp    = r_sp;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//==============================================================================
// Module : pc_sequencer
// Brief  : Program counter, fetch/execute phase, fetch register and CALL/RET stack.
//          Build option: PC_SEQ_STACK_CIRCULAR_EN (circular return stack, no overflow error).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int BYTE_W      = 8,
  parameter int OPC_W       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BYTE_W-1:0]       program_byte,
  input  logic                    inc_pc,
  input  logic                    load_pc,
  input  logic                    call,
  input  logic                    ret,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic                    stall,
  input  logic                    err_clr,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    phase,
  output logic [OPC_W-1:0]        instr,
  output logic [BYTE_W-OPC_W-1:0] oprnd,
  output logic [SP_W-1:0]         sp,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic                    stack_err
);

  logic [ADDR_W-1:0]       r_pc;
  logic                    r_phase;
  logic [OPC_W-1:0]        r_instr;
  logic [BYTE_W-OPC_W-1:0] r_oprnd;
  logic                    r_err;

  logic [ADDR_W-1:0]       w_pc_inc;
  logic [ADDR_W-1:0]       w_pc_next;
  logic [ADDR_W-1:0]       w_stk_top;
  stack_op_t               w_stk_op;
  logic                    w_err_set;
  logic                    w_full;
  logic                    w_empty;

  assign w_pc_inc = ADDR_W'(next_pc(32'(r_pc)));

  always_comb begin
    w_pc_next = r_pc;
    w_stk_op  = STK_NONE;
    w_err_set = 1'b0;
    if (call && ret) begin
      // Conflicting stack request: stack untouched, PC falls to jump/increment.
      w_err_set = 1'b1;
      if (load_pc)     w_pc_next = load_addr;
      else if (inc_pc) w_pc_next = w_pc_inc;
    end else if (ret) begin
      if (w_empty) begin
        w_pc_next = w_pc_inc;
        w_err_set = 1'b1;
      end else begin
        w_pc_next = w_stk_top;
        w_stk_op  = STK_POP;
      end
    end else if (call) begin
      w_pc_next = load_addr;
      if (w_full && !STACK_CIRCULAR) w_err_set = 1'b1;
      else                           w_stk_op  = STK_PUSH;
    end else if (load_pc) begin
      w_pc_next = load_addr;
    end else if (inc_pc) begin
      w_pc_next = w_pc_inc;
    end
    if (stall) begin
      w_pc_next = r_pc;
      w_stk_op  = STK_NONE;
      w_err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= ADDR_W'(PC_RESET_VAL);
      r_phase <= PHASE_FETCH;
      r_instr <= '0;
      r_oprnd <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_err <= w_err_set | (r_err & ~err_clr);
      if (!stall) begin
        r_phase <= ~r_phase;
        if (r_phase == PHASE_FETCH) begin
          r_instr <= program_byte[BYTE_W-1 -: OPC_W];
          r_oprnd <= program_byte[BYTE_W-OPC_W-1:0];
        end
      end
    end
  end

  ret_stack #(
    .DEPTH    (STACK_DEPTH),
    .WIDTH    (ADDR_W),
    .CIRCULAR (STACK_CIRCULAR)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .op        (w_stk_op),
    .push_data (w_pc_inc),
    .top       (w_stk_top),
    .sp        (sp),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign rom_addr    = r_pc;
  assign phase       = r_phase;
  assign instr       = r_instr;
  assign oprnd       = r_oprnd;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = r_err;

endmodule

`default_nettype wire
